reg_bank_rd_serial: RTL and testbench
=====================================

// Module: reg_bank_rd_serial
// PURPOSE
//   Read-side companion to the 3-register load bank: snapshots the DREG1/DREG2/DREG3 register
//   outputs on request and streams the selected registers out bit-serially, LSB first,
//   over a valid/ready handshake. Sits between the register bank and a serial sink (debug port / link).
//   Supplies frame status (BUSY, DONE, current register ID) to the controlling logic.
// PARAMETERS
//   W1  8  width of DREG1 input / register-1 field (1..16)
//   W2  6  width of DREG2 input / register-2 field (1..16)
//   W3  4  width of DREG3 input / register-3 field (1..16)
// PORTS
//   CLK     in   1       clock, all logic on rising edge
//   RST     in   1       synchronous, active-high reset
//   DREG1   in   W1      register-1 contents
//   DREG2   in   W2      register-2 contents
//   DREG3   in   W3      register-3 contents
//   SEL     in   3       register select mask: bit0=DREG1, bit1=DREG2, bit2=DREG3
//   START   in   1       frame request, sampled only in IDLE
//   SRDY    in   1       sink ready
//   SDO     out  1       serial data bit
//   SVLD    out  1       SDO valid; bit transferred when SVLD & SRDY at a rising edge
//   REG_ID  out  2       register currently shifting (1/2/3), 0 when not shifting
//   BUSY    out  1       frame in progress
//   DONE    out  1       one-cycle pulse at frame end
// BEHAVIOUR
//   - Reset (RST=1 at an edge): state IDLE; SDO=0, SVLD=0, REG_ID=0, BUSY=0, DONE=0; snapshot regs cleared.
//     Reset mid-frame abandons the frame at that edge; no DONE pulse is issued.
//   - States: IDLE -> SHIFT -> FIN -> IDLE.
//   - IDLE: START=1 and SEL!=0 -> at the edge, capture DREG1..3 and SEL into snapshot regs and enter SHIFT.
//     SVLD=1, BUSY=1, SDO=bit0 of the first selected register, all visible the following cycle (latency 1).
//   - IDLE: START=1 and SEL==0 -> go to FIN directly; DONE pulses next cycle, SVLD never asserts.
//   - SHIFT: registers are sent in order 1,2,3; unselected registers are skipped with no gap cycle.
//     Each register sends Wn bits, LSB first.
//     On SVLD&SRDY the next bit is presented the next cycle. With SRDY=0, SDO and REG_ID hold stable.
//     When the last bit of the last selected register is accepted: next cycle FIN,
//     with SVLD=0, BUSY=0, REG_ID=0, DONE=1.
//   - FIN: lasts exactly one cycle, then IDLE. START is ignored in SHIFT and FIN: no restart, no queueing.
//   - DREG*/SEL changes after capture have no effect on the frame in flight.
//   - Bit counter width = clog2(max(W1,W2,W3)+1). Frame length = sum of selected Wn (+ parity bits, see below).
//   - Gapless: with SRDY tied 1, the frame occupies exactly N consecutive SVLD cycles.
// CONFIGURATION
//   REG_BANK_RD_PARITY_EN defined: after the last data bit of each register, one extra bit is sent,
//     with REG_ID unchanged. That bit is even parity (XOR of the register's snapshot bits).
//     Frame length = sum(Wn) + number of selected registers.
//   Not defined: no parity bits; the frame is data bits only.
// TESTING
//   1) SEL=111, DREG1=A5, DREG2=2C, DREG3=9, SRDY=1, pulse START -> SVLD high 18 cycles.
//      SDO=1,0,1,0,0,1,0,1 | 0,0,1,1,0,1 | 1,0,0,1; REG_ID 1x8, 2x6, 3x4; DONE pulse on cycle 19.
//   2) SEL=100, DREG3=6, SRDY toggling 1,0,1,0.. -> SDO 0,1,1,0, each bit held through SRDY=0 cycles.
//      REG_ID=3 throughout; DONE after the 4th accepted bit.
//   3) SEL=000, START -> DONE=1 for one cycle on the next cycle; SVLD and BUSY stay 0.
//   4) SEL=001, DREG1=FF, START; change DREG1 to 00 and pulse START again after 3 bits
//      -> all 8 bits =1, a single DONE, no second frame.
//   5) SEL=111, SRDY=1, assert RST after 5 accepted bits -> next cycle SVLD=BUSY=DONE=0, REG_ID=0.
//      A new START then produces a complete, correct frame.
//   6) [REG_BANK_RD_PARITY_EN] SEL=001, DREG1=07 -> 9 bits 1,1,1,0,0,0,0,0,1; DONE after the 9th bit.

Source files
------------

// File: rtl/reg_bank_rd_serial.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_rd_serial
// Purpose  : Read-side companion to the 3-register load bank. On a START
//            request it snapshots the register outputs and the select mask.
//            It then streams the selected registers out bit-serially, LSB
//            first, over a valid/ready handshake. Frame status is reported
//            alongside the stream.
// Ports    : clk     - clock, rising edge
//            rst     - synchronous active-high reset
//            dreg1/2/3 - register contents (W1/W2/W3 bits)
//            sel     - select mask, bit0=dreg1, bit1=dreg2, bit2=dreg3
//            start   - frame request, honoured only when idle
//            srdy    - sink ready
//            sdo     - serial data bit
//            svld    - sdo valid (transfer on svld & srdy)
//            reg_id  - register currently shifting (1..3), 0 otherwise
//            busy    - frame in progress
//            done    - one-cycle pulse at frame end
// Options  : define REG_BANK_RD_PARITY_EN to append one even-parity bit after
//            the data bits of each register.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_rd_serial #(
    parameter int W1 = 8,
    parameter int W2 = 6,
    parameter int W3 = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W1-1:0] dreg1,
    input  logic [W2-1:0] dreg2,
    input  logic [W3-1:0] dreg3,
    input  logic [2:0]    sel,
    input  logic          start,
    input  logic          srdy,
    output logic          sdo,
    output logic          svld,
    output logic [1:0]    reg_id,
    output logic          busy,
    output logic          done
);

    localparam int c_wmax = (W1 > W2) ? ((W1 > W3) ? W1 : W3)
                                      : ((W2 > W3) ? W2 : W3);
    localparam int CW     = $clog2(c_wmax + 1);

`ifdef REG_BANK_RD_PARITY_EN
    localparam int c_par  = 1;
`else
    localparam int c_par  = 0;
`endif

    // Index of the final bit of each register; the parity bit (when enabled)
    // sits at index Wn, which still fits in CW bits.
    localparam logic [CW-1:0] c_last1 = CW'(W1 - 1 + c_par);
    localparam logic [CW-1:0] c_last2 = CW'(W2 - 1 + c_par);
    localparam logic [CW-1:0] c_last3 = CW'(W3 - 1 + c_par);
    localparam logic [CW-1:0] c_w1    = CW'(W1);
    localparam logic [CW-1:0] c_w2    = CW'(W2);
    localparam logic [CW-1:0] c_w3    = CW'(W3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    state_t          r_state;
    logic [W1-1:0]   r_d1;
    logic [W2-1:0]   r_d2;
    logic [W3-1:0]   r_d3;
    logic [2:0]      r_sel;
    logic [1:0]      r_cur;
    logic [CW-1:0]   r_cnt;
    logic            r_sdo;
    logic            r_svld;
    logic [1:0]      r_reg_id;
    logic            r_busy;
    logic            r_done;

    logic [1:0]      w_first_id;
    logic [1:0]      w_next_id;
    logic            w_last_bit;
    logic [CW-1:0]   w_cnt_inc;

    // Smallest selected register number strictly above id, 0 if none.
    function automatic logic [1:0] f_next(input logic [2:0] s, input logic [1:0] id);
        if      (id < 2'd1 && s[0]) f_next = 2'd1;
        else if (id < 2'd2 && s[1]) f_next = 2'd2;
        else if (id < 2'd3 && s[2]) f_next = 2'd3;
        else                        f_next = 2'd0;
    endfunction

    function automatic logic [CW-1:0] f_last(input logic [1:0] id);
        case (id)
            2'd2:    f_last = c_last2;
            2'd3:    f_last = c_last3;
            default: f_last = c_last1;
        endcase
    endfunction

    // Bit idx of register id; an index equal to the register width selects
    // the even-parity bit of that register.
    function automatic logic f_bit(input logic [1:0]    id,
                                   input logic [CW-1:0] idx,
                                   input logic [W1-1:0] a,
                                   input logic [W2-1:0] b,
                                   input logic [W3-1:0] c);
        logic [W1-1:0] sa;
        logic [W2-1:0] sb;
        logic [W3-1:0] sc;
        sa = a >> idx;
        sb = b >> idx;
        sc = c >> idx;
        case (id)
            2'd1:    f_bit = (idx < c_w1) ? sa[0] : ^a;
            2'd2:    f_bit = (idx < c_w2) ? sb[0] : ^b;
            2'd3:    f_bit = (idx < c_w3) ? sc[0] : ^c;
            default: f_bit = 1'b0;
        endcase
    endfunction

    assign w_first_id = f_next(sel, 2'd0);
    assign w_next_id  = f_next(r_sel, r_cur);
    assign w_last_bit = (r_cnt == f_last(r_cur));
    assign w_cnt_inc  = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_d1     <= '0;
            r_d2     <= '0;
            r_d3     <= '0;
            r_sel    <= '0;
            r_cur    <= '0;
            r_cnt    <= '0;
            r_sdo    <= 1'b0;
            r_svld   <= 1'b0;
            r_reg_id <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (sel != 3'b000) begin
                            r_d1     <= dreg1;
                            r_d2     <= dreg2;
                            r_d3     <= dreg3;
                            r_sel    <= sel;
                            r_cur    <= w_first_id;
                            r_cnt    <= '0;
                            r_reg_id <= w_first_id;
                            // First bit comes from the live inputs, which are
                            // exactly what the snapshot captures at this edge.
                            r_sdo    <= f_bit(w_first_id, '0, dreg1, dreg2, dreg3);
                            r_svld   <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= ST_SHIFT;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (r_svld && srdy) begin
                        if (w_last_bit) begin
                            if (w_next_id == 2'd0) begin
                                r_sdo    <= 1'b0;
                                r_svld   <= 1'b0;
                                r_busy   <= 1'b0;
                                r_reg_id <= '0;
                                r_cur    <= '0;
                                r_done   <= 1'b1;
                                r_state  <= ST_FIN;
                            end else begin
                                // Move straight to the next selected register.
                                r_cur    <= w_next_id;
                                r_cnt    <= '0;
                                r_reg_id <= w_next_id;
                                r_sdo    <= f_bit(w_next_id, '0, r_d1, r_d2, r_d3);
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                            r_sdo <= f_bit(r_cur, w_cnt_inc, r_d1, r_d2, r_d3);
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sdo    = r_sdo;
    assign svld   = r_svld;
    assign reg_id = r_reg_id;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_rd_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_rd_serial
// Purpose  : Directed self-checking bench for reg_bank_rd_serial. Covers the
//            reset state, full frame, register skipping, backpressure, empty
//            select, start-ignore and snapshot, mid-frame reset, and the
//            parity option (REG_BANK_RD_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_rd_serial;

    logic       clk;
    logic       rst;
    logic [7:0] dreg1;
    logic [5:0] dreg2;
    logic [3:0] dreg3;
    logic [2:0] sel;
    logic       start;
    logic       srdy;
    logic       sdo;
    logic       svld;
    logic [1:0] reg_id;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    reg_bank_rd_serial #(.W1(8), .W2(6), .W3(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .dreg1  (dreg1),
        .dreg2  (dreg2),
        .dreg3  (dreg3),
        .sel    (sel),
        .start  (start),
        .srdy   (srdy),
        .sdo    (sdo),
        .svld   (svld),
        .reg_id (reg_id),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; srdy = 1'b1; sel = 3'b111;
        dreg1 = 8'hA5; dreg2 = 6'h2C; dreg3 = 4'h9;
        tick(); tick();
        checks++;
        if ({sdo, svld, reg_id, busy, done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_state: sdo=%b svld=%b reg_id=%0d busy=%b done=%b, want all 0",
                     sdo, svld, reg_id, busy, done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame(input string tag);
        logic [0:20] e;
        int n, n1, n2;
        logic [1:0] eid;
`ifdef REG_BANK_RD_PARITY_EN
        e = 21'b101001010_0011011_10010; n = 21; n1 = 9; n2 = 16;
`else
        e = {18'b10100101_001101_1001, 3'b000}; n = 18; n1 = 8; n2 = 14;
`endif
        dreg1 = 8'hA5; dreg2 = 6'h2C; dreg3 = 4'h9; sel = 3'b111; srdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            eid = (i < n1) ? 2'd1 : (i < n2) ? 2'd2 : 2'd3;
            checks++;
            if (svld !== 1'b1 || busy !== 1'b1 || sdo !== e[i] || reg_id !== eid || done !== 1'b0) begin
                failures++;
                $display("FAIL %s bit%0d: svld=%b busy=%b sdo=%b reg_id=%0d done=%b, want 1 1 %b %0d 0",
                         tag, i, svld, busy, sdo, reg_id, done, e[i], eid);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || svld !== 1'b0 || busy !== 1'b0 || reg_id !== 2'd0) begin
            failures++;
            $display("FAIL %s end: done=%b svld=%b busy=%b reg_id=%0d, want 1 0 0 0",
                     tag, done, svld, busy, reg_id);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_width: done=%b, want 0", tag, done);
        end
    endtask

    task automatic test_skip();
        logic [0:13] e;
        int n, n1;
        logic [1:0] eid;
`ifdef REG_BANK_RD_PARITY_EN
        e = 14'b101001010_10010; n = 14; n1 = 9;
`else
        e = {12'b10100101_1001, 2'b00}; n = 12; n1 = 8;
`endif
        dreg1 = 8'hA5; dreg2 = 6'h3F; dreg3 = 4'h9; sel = 3'b101; srdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            eid = (i < n1) ? 2'd1 : 2'd3;
            checks++;
            if (svld !== 1'b1 || sdo !== e[i] || reg_id !== eid) begin
                failures++;
                $display("FAIL skip bit%0d: svld=%b sdo=%b reg_id=%0d, want 1 %b %0d",
                         i, svld, sdo, reg_id, e[i], eid);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || svld !== 1'b0) begin
            failures++;
            $display("FAIL skip end: done=%b svld=%b, want 1 0", done, svld);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [0:4] e;
        int n;
`ifdef REG_BANK_RD_PARITY_EN
        e = 5'b01100; n = 5;
`else
        e = 5'b01100; n = 4;
`endif
        dreg1 = 8'h00; dreg2 = 6'h00; dreg3 = 4'h6; sel = 3'b100; srdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            srdy = 1'b0;
            tick();
            checks++;
            if (svld !== 1'b1 || sdo !== e[k] || reg_id !== 2'd3 || done !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold bit%0d: svld=%b sdo=%b reg_id=%0d done=%b, want 1 %b 3 0",
                         k, svld, sdo, reg_id, done, e[k]);
            end
            srdy = 1'b1;
            tick();
        end
        checks++;
        if (done !== 1'b1 || svld !== 1'b0 || reg_id !== 2'd0) begin
            failures++;
            $display("FAIL bp_end: done=%b svld=%b reg_id=%0d, want 1 0 0", done, svld, reg_id);
        end
        tick();
    endtask

    task automatic test_empty_sel();
        sel = 3'b000; srdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || svld !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_sel: done=%b svld=%b busy=%b, want 1 0 0", done, svld, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || svld !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_sel_after: done=%b svld=%b busy=%b, want 0 0 0", done, svld, busy);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        int ndone;
        logic eb;
`ifdef REG_BANK_RD_PARITY_EN
        n = 9;
`else
        n = 8;
`endif
        ndone = 0;
        dreg1 = 8'hFF; sel = 3'b001; srdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == 3) begin
                dreg1 = 8'h00; sel = 3'b111; start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            eb = (i < 8) ? 1'b1 : 1'b0;   // parity of 0xFF is 0
            checks++;
            if (svld !== 1'b1 || sdo !== eb || reg_id !== 2'd1) begin
                failures++;
                $display("FAIL snapshot bit%0d: svld=%b sdo=%b reg_id=%0d, want 1 %b 1",
                         i, svld, sdo, reg_id, eb);
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) ndone++;
            checks++;
            if (svld !== 1'b0) begin
                failures++;
                $display("FAIL no_restart cycle%0d: svld=%b, want 0", i, svld);
            end
            tick();
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL single_done: done pulses=%0d, want 1", ndone);
        end
        sel = 3'b111;
    endtask

    task automatic test_reset_midframe();
        dreg1 = 8'hA5; dreg2 = 6'h2C; dreg3 = 4'h9; sel = 3'b111; srdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (svld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || reg_id !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset: svld=%b busy=%b done=%b reg_id=%0d, want 0 0 0 0",
                     svld, busy, done, reg_id);
        end
        tick();
        checks++;
        if (done !== 1'b0 || svld !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_after: done=%b svld=%b, want 0 0", done, svld);
        end
        test_full_frame("after_reset");
    endtask

`ifdef REG_BANK_RD_PARITY_EN
    task automatic test_parity();
        logic [0:8] e;
        e = 9'b111000001;
        dreg1 = 8'h07; sel = 3'b001; srdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (svld !== 1'b1 || sdo !== e[i] || reg_id !== 2'd1) begin
                failures++;
                $display("FAIL parity bit%0d: svld=%b sdo=%b reg_id=%0d, want 1 %b 1",
                         i, svld, sdo, reg_id, e[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || svld !== 1'b0) begin
            failures++;
            $display("FAIL parity_end: done=%b svld=%b, want 1 0", done, svld);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame("full_frame");
        test_skip();
        test_backpressure();
        test_empty_sel();
        test_start_ignored();
        test_reset_midframe();
`ifdef REG_BANK_RD_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
